// File: rtl/pov_spi_loader.sv
// Double-buffered view-vector loader: an SPI mode-0 link fills a pending set that is
// applied to the live outputs on a frame tick. Define POV_READBACK_EN to add o_miso readback.
module pov_spi_loader #(
  parameter int FW   = 16,
  parameter int FRAC = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_sclk,
  input  logic          i_mosi,
  input  logic          i_csb,
  input  logic          i_frame_tick,
  output logic [FW-1:0] o_playerX,
  output logic [FW-1:0] o_playerY,
  output logic [FW-1:0] o_facingX,
  output logic [FW-1:0] o_facingY,
  output logic [FW-1:0] o_vplaneX,
  output logic [FW-1:0] o_vplaneY,
  output logic          o_pending,
  output logic          o_loaded,
  output logic          o_error,
`ifdef POV_READBACK_EN
  output logic          o_miso,
`endif
  output logic [1:0]    o_dbg_state
);

  localparam int VW = 6 * FW;
  localparam int CW = $clog2(VW + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(VW);
  localparam logic [CW-1:0] CNT_MAX  = CW'(VW + 1);

  localparam logic [FW-1:0] ONE      = FW'(1) << FRAC;
  localparam logic [FW-1:0] HALF     = ONE >> 1;
  localparam logic [FW-1:0] ONE_HALF = ONE + HALF;
  localparam logic [VW-1:0] LIVE_RST = {ONE_HALF, ONE_HALF, {FW{1'b0}}, ONE, HALF, {FW{1'b0}}};

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

  state_t          state;
  logic [2:0]      sclk_sr;
  logic [2:0]      csb_sr;
  logic [1:0]      mosi_sr;
  logic [VW-1:0]   shreg;
  logic [VW-1:0]   pend_buf;
  logic [VW-1:0]   live_q;
  logic [CW-1:0]   bit_cnt;
  logic            pending_q;
  logic            loaded_q;
  logic            error_q;

  logic csb_s, csb_fall, csb_rise, sclk_rise, mosi_s;

  // Bit [1] is the synchronised level, bit [2] its previous value for edge detection;
  // mosi takes the same two stages so it stays aligned with the sclk edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sr <= '0;
      csb_sr  <= '0;
      mosi_sr <= '0;
    end else begin
      sclk_sr <= {sclk_sr[1:0], i_sclk};
      csb_sr  <= {csb_sr[1:0], i_csb};
      mosi_sr <= {mosi_sr[0], i_mosi};
    end
  end

  assign csb_s     = csb_sr[1];
  assign csb_fall  = ~csb_sr[1] & csb_sr[2];
  assign csb_rise  = csb_sr[1] & ~csb_sr[2];
  assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
  assign mosi_s    = mosi_sr[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= WAIT_IDLE;
      shreg     <= '0;
      pend_buf  <= '0;
      live_q    <= LIVE_RST;
      bit_cnt   <= '0;
      pending_q <= 1'b0;
      loaded_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      loaded_q <= 1'b0;
      // Apply reads the pre-commit pending flag; a same-cycle commit below overrides it.
      if (i_frame_tick && pending_q) begin
        live_q    <= pend_buf;
        pending_q <= 1'b0;
        loaded_q  <= 1'b1;
      end
      case (state)
        WAIT_IDLE: begin
          if (csb_s) state <= IDLE;
        end
        IDLE: begin
          if (csb_fall) begin
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (csb_rise) begin
            state <= IDLE;
            if (bit_cnt == CNT_FULL) begin
              pend_buf  <= shreg;
              pending_q <= 1'b1;
              error_q   <= 1'b0;
            end else begin
              error_q <= 1'b1;
            end
          end else if (sclk_rise && !csb_s) begin
            shreg <= {shreg[VW-2:0], mosi_s};
            if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

`ifdef POV_READBACK_EN
  logic [VW-1:0] rb_q;
  logic          sclk_fall;

  assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];

  // Snapshot of the live set, shifted out on sclk falling so the master samples on rising.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rb_q <= '0;
    end else if (state != WAIT_IDLE && csb_fall) begin
      rb_q <= live_q;
    end else if (sclk_fall && !csb_s) begin
      rb_q <= {rb_q[VW-2:0], 1'b0};
    end
  end

  assign o_miso = rb_q[VW-1] & ~csb_s & (state != WAIT_IDLE);
`endif

  assign o_playerX   = live_q[6*FW-1 -: FW];
  assign o_playerY   = live_q[5*FW-1 -: FW];
  assign o_facingX   = live_q[4*FW-1 -: FW];
  assign o_facingY   = live_q[3*FW-1 -: FW];
  assign o_vplaneX   = live_q[2*FW-1 -: FW];
  assign o_vplaneY   = live_q[FW-1 -: FW];
  assign o_pending   = pending_q;
  assign o_loaded    = loaded_q;
  assign o_error     = error_q;
  assign o_dbg_state = state;

endmodule

// File: tb/tb_pov_spi_loader.sv
// Bench for pov_spi_loader: directed and randomized SPI transfers against a
// set-level model of pending/live/error behaviour.
module tb_pov_spi_loader;

  localparam int FW = 16;
  localparam int VW = 6 * FW;
  localparam logic [VW-1:0] RST_LIVE =
    {16'h0180, 16'h0180, 16'h0000, 16'h0100, 16'h0080, 16'h0000};

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic sclk, mosi, csb, tick;
  logic [FW-1:0] px, py, fx, fy, vx, vy;
  logic pending, loaded, error;
  logic [1:0] dbg_state;
`ifdef POV_READBACK_EN
  logic miso;
`endif

  pov_spi_loader #(.FW(FW), .FRAC(8)) dut (
    .clk(clk), .reset_n(reset_n), .i_sclk(sclk), .i_mosi(mosi), .i_csb(csb),
    .i_frame_tick(tick),
    .o_playerX(px), .o_playerY(py), .o_facingX(fx), .o_facingY(fy),
    .o_vplaneX(vx), .o_vplaneY(vy),
    .o_pending(pending), .o_loaded(loaded), .o_error(error),
`ifdef POV_READBACK_EN
    .o_miso(miso),
`endif
    .o_dbg_state(dbg_state)
  );

  logic [VW-1:0] live_obs;
  assign live_obs = {px, py, fx, fy, vx, vy};

  // reference model: whole-set view of the loader
  logic [VW-1:0] m_live, m_pend;
  logic          m_pflag, m_err;
  logic [VW-1:0] rb_cap;
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_live"}, live_obs, m_live);
    check({tag, "_pending"}, VW'(pending), VW'(m_pflag));
    check({tag, "_error"}, VW'(error), VW'(m_err));
  endtask

  task automatic model_reset();
    m_live  = RST_LIVE;
    m_pend  = '0;
    m_pflag = 1'b0;
    m_err   = 1'b0;
  endtask

  // driver: one mode-0 bit, master samples miso just before its rising edge
  task automatic sclk_bit(input logic b);
    mosi = b;
    step(4);
`ifdef POV_READBACK_EN
    rb_cap = {rb_cap[VW-2:0], miso};
`endif
    sclk = 1'b1;
    step(4);
    sclk = 1'b0;
  endtask

  // full transaction; tick_same=1 pulses the frame tick in the commit cycle
  task automatic spi_xfer(input string tag, input logic [VW-1:0] data, input int nbits,
                          input bit tick_same);
    logic [VW-1:0] live_at_start;
    logic was_pending;
    live_at_start = m_live;
    rb_cap = '0;
    csb = 1'b0;
    step(4);
    for (int i = 0; i < nbits; i++) begin
      if (i < VW) sclk_bit(data[VW-1-i]);
      else        sclk_bit(1'($urandom_range(0, 1)));
    end
    step(4);
    check({tag, "_pre_live"}, live_obs, m_live);
    csb = 1'b1;
    was_pending = m_pflag;
    if (tick_same) begin
      step(2);
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      check({tag, "_same_loaded"}, VW'(loaded), VW'(was_pending));
      if (was_pending) begin
        m_live  = m_pend;
        m_pflag = 1'b0;
      end
    end
    if (nbits == VW) begin
      m_pend  = data;
      m_pflag = 1'b1;
      m_err   = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    step(6);
    check_state(tag);
`ifdef POV_READBACK_EN
    if (nbits == VW) check({tag, "_miso"}, rb_cap, live_at_start);
`endif
  endtask

  task automatic frame_tick(input string tag);
    logic was_pending;
    was_pending = m_pflag;
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    if (was_pending) begin
      m_live  = m_pend;
      m_pflag = 1'b0;
    end
    check({tag, "_loaded"}, VW'(loaded), VW'(was_pending));
    check({tag, "_live"}, live_obs, m_live);
    step(1);
    check({tag, "_loaded_clr"}, VW'(loaded), VW'(0));
    check({tag, "_pending"}, VW'(pending), VW'(m_pflag));
  endtask

  initial begin
    logic [VW-1:0] d, a, b;
    int nb;
    reset_n = 1'b0;
    sclk = 1'b0; mosi = 1'b0; csb = 1'b1; tick = 1'b0;
    rb_cap = '0;
    model_reset();
    step(3);
    check("rst_loaded", VW'(loaded), VW'(0));
    check_state("rst_low");
    reset_n = 1'b1;
    step(6);
    check_state("rst");
    frame_tick("tick_idle");

    d = {16'h0200, 16'h0300, 16'hFF00, 16'h0000, 16'h0000, 16'h0080};
    spi_xfer("good1", d, VW, 1'b0);
    frame_tick("apply1");

    spi_xfer("short95", VW'($urandom), VW - 1, 1'b0);
    spi_xfer("long97", VW'($urandom), VW + 1, 1'b0);
    d = {$urandom, $urandom, $urandom};
    spi_xfer("good2", d, VW, 1'b0);
    frame_tick("apply2");

    a = {$urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom};
    spi_xfer("xfer_a", a, VW, 1'b0);
    spi_xfer("xfer_b", b, VW, 1'b0);
    frame_tick("apply_b");
    check("apply_b_val", live_obs, b);
    frame_tick("tick_again");

    // commit coinciding with a tick, first with nothing pending, then with a set pending
    spi_xfer("same_nopend", {$urandom, $urandom, $urandom}, VW, 1'b1);
    spi_xfer("same_pend", {$urandom, $urandom, $urandom}, VW, 1'b1);
    frame_tick("apply_same");

    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 3))
        0:       nb = VW - 1;
        1:       nb = VW + 1;
        default: nb = VW;
      endcase
      spi_xfer($sformatf("rnd%0d", k), {$urandom, $urandom, $urandom}, nb,
               1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) frame_tick($sformatf("rnd_tick%0d", k));
    end

    // reset in the middle of a transfer with csb held low
    spi_xfer("pre_mid", {$urandom, $urandom, $urandom}, VW, 1'b0);
    d = {$urandom, $urandom, $urandom};
    csb = 1'b0;
    step(4);
    for (int i = 0; i < 40; i++) sclk_bit(d[VW-1-i]);
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    model_reset();
    for (int i = 40; i < VW; i++) sclk_bit(d[VW-1-i]);
    step(4);
    csb = 1'b1;
    step(6);
    check_state("mid_rst");
    frame_tick("mid_rst_tick");
    d = {$urandom, $urandom, $urandom};
    spi_xfer("post_rst", d, VW, 1'b0);
    frame_tick("post_rst_apply");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
